mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-ported RV32I memory (8 kB RAM plus memory-mapped LED/millis/micros peripherals) between the instruction-fetch unit and the load/store unit.
- Issues at most one access per cycle and tracks the memory's 1-cycle registered read latency.
- Routes each read result back to the requester that issued it.
- Data port has priority; a starvation guard guarantees fetch progress.

Parameters:
MAX_DATA_STREAK, 4, consecutive data grants allowed while if_req is pending before fetch is forced to win one cycle (range 1..15)
CNT_W, 16, width of saturating contention counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
if_req  input  1  fetch read request, held until granted
if_addr  input  32  fetch byte address (word aligned)
if_gnt  output  1  fetch request accepted this cycle (combinational)
if_rvalid  output  1  fetch data valid (registered, one cycle after if_gnt)
if_rdata  output  32  fetch word
d_req  input  1  load/store request, held until granted
d_we  input  1  1 = store, 0 = load
d_funct3  input  3  RV32I funct3 of the load/store
d_addr  input  32  load/store byte address
d_wdata  input  32  store data (unshifted, as the memory expects)
d_gnt  output  1  data request accepted this cycle (combinational)
d_rvalid  output  1  load data valid (registered, one cycle after d_gnt of a load)
d_rdata  output  32  load result (already extended by the memory)
mem_write_mem  output  1  to memory write_mem
mem_funct3  output  3  to memory funct3
mem_write_address  output  32  to memory write_address
mem_write_data  output  32  to memory write_data
mem_read_address  output  32  to memory read_address
mem_read_data  input  32  from memory read_data
contention_count  output  CNT_W  cycles in which both ports requested and one was refused; saturating

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port rst.
- Reset values: rd_pending=0, rd_owner=IF, streak=0, contention_count=0.
- While rst=1: if_gnt=0, d_gnt=0, if_rvalid=0, d_rvalid=0, and memory outputs are in the idle state.
- Idle memory drive (no grant this cycle): mem_write_mem=0, mem_funct3=3'b010, all addresses and write data 0.
- Grant selection, each cycle with rst=0:
  - Only d_req: data wins.
  - Only if_req: fetch wins.
  - Both: data wins, unless streak==MAX_DATA_STREAK, in which case fetch wins.
  - At most one of if_gnt/d_gnt is high.
- Streak counter:
  - Increments on a data grant while if_req=1.
  - Clears on any fetch grant or when if_req=0.
  - Never exceeds MAX_DATA_STREAK.
- Fetch grant: mem_read_address=if_addr, mem_funct3=3'b010, mem_write_mem=0.
- Data load grant: mem_read_address=d_addr, mem_funct3=d_funct3, mem_write_mem=0.
- Data store grant:
  - mem_write_address=d_addr, mem_write_data=d_wdata, mem_funct3=d_funct3, mem_write_mem=1.
  - mem_read_address=0.
  - Store is complete at d_gnt; no d_rvalid follows.
- Read return:
  - A read grant sets rd_pending=1 and rd_owner=granted port on the next edge.
  - While rd_pending=1: owner's rvalid=1 and owner's rdata=mem_read_data (combinational pass-through). The other port's rdata=0.
  - rd_pending reloads every cycle from the current grant, so back-to-back reads complete one per cycle with no bubble.
- Pass-through timing: mem_read_data is combinational from the memory's output registers and the latched funct3. The arbiter must therefore keep mem_funct3 driven only by the current grant; memory internally latches it with the address.
- Simultaneous events: a store grant in the same cycle as a pending read return is legal. The return uses the previous cycle's latched funct3.
- contention_count increments when if_req&d_req&rst=0, and saturates at 2^CNT_W-1.
- Reset mid-operation: a read granted in the cycle before rst rises produces no rvalid. rst forces rd_pending=0 at that edge.
- Requesters must hold req/addr/data stable until gnt. The arbiter does not register requests.

Decomposition:
- Package mem_arb_pkg:
  - owner_e enum {OWNER_IF, OWNER_D}
  - FUNCT3_LW=3'b010
  - STREAK_W=4
- Sub-module mem_arb_grant: grant pick plus the streak counter. It takes if_req, d_req, rst and outputs if_gnt/d_gnt.
- The top level holds the mux, the return tracking and contention_count.

Test Plan:
- Fetch only, if_addr=0x100 with word 0x00500093 preloaded → if_gnt=1 in cycle 0; if_rvalid=1 with if_rdata=0x00500093 in cycle 1; d_rvalid stays 0.
- Back-to-back fetches at 0x0, 0x4, 0x8 → three gnts in consecutive cycles; rvalid high for 3 consecutive cycles with the correct words in order.
- Store then load: d_we=1, funct3=3'b000, addr=0x203, wdata=0xAB; next cycle load funct3=3'b100, addr=0x203 → d_rvalid one cycle after the load grant with d_rdata=0x000000AB; no rvalid after the store.
- Both ports requesting continuously, MAX_DATA_STREAK=4 → grant pattern D,D,D,D,IF repeating; contention_count=10 after 10 cycles.
- Load lh at 0xFFFFFFF4 concurrent with if_req → data granted first; d_rdata equals the sign-extended micros[15:0]; fetch granted the next cycle.
- rst asserted the cycle after a fetch grant → no if_rvalid; all outputs 0 and contention_count=0 on the next cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_e;

  localparam logic [2:0]  FUNCT3_LW = 3'b010;
  localparam int unsigned STREAK_W  = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, load/store port and single memory port bundled together.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        mem_write_mem;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_address;
  logic [31:0] mem_read_data;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata, mem_read_data,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_write_mem, mem_funct3, mem_write_address, mem_write_data, mem_read_address
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata, mem_read_data,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_write_mem, mem_funct3, mem_write_address, mem_write_data, mem_read_address
  );

endinterface

// File: rtl/mem_arb_grant.sv
// Fixed data-first grant with a streak counter that forces one fetch grant
// after MAX_DATA_STREAK consecutive data wins against a waiting fetch.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_if_req,
  input  logic i_d_req,
  output logic o_if_gnt,
  output logic o_d_gnt
);

  logic [STREAK_W-1:0] r_streak;
  logic                w_force_if;

  assign w_force_if = (r_streak == STREAK_W'(MAX_DATA_STREAK));

  always_comb begin
    o_if_gnt = 1'b0;
    o_d_gnt  = 1'b0;
    if (!rst) begin
      if (i_d_req && !(i_if_req && w_force_if)) begin
        o_d_gnt = 1'b1;
      end else if (i_if_req) begin
        o_if_gnt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_streak <= '0;
    end else if (!i_if_req || o_if_gnt) begin
      r_streak <= '0;
    end else if (o_d_gnt && !w_force_if) begin
      r_streak <= r_streak + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, steering each
// registered read result back to the port that issued it.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus,
  output logic [CNT_W-1:0] contention_count
);

  logic   w_if_gnt;
  logic   w_d_gnt;
  logic   w_rd_gnt;
  logic   w_if_rvalid;
  logic   w_d_rvalid;
  logic   r_rd_pending;
  owner_e r_rd_owner;
  logic [CNT_W-1:0] r_contention;

  mem_arb_grant #(
    .MAX_DATA_STREAK (MAX_DATA_STREAK)
  ) u_grant (
    .clk      (clk),
    .rst      (rst),
    .i_if_req (bus.if_req),
    .i_d_req  (bus.d_req),
    .o_if_gnt (w_if_gnt),
    .o_d_gnt  (w_d_gnt)
  );

  assign bus.if_gnt = w_if_gnt;
  assign bus.d_gnt  = w_d_gnt;
  assign w_rd_gnt   = w_if_gnt | (w_d_gnt & ~bus.d_we);

  always_comb begin
    bus.mem_write_mem     = 1'b0;
    bus.mem_funct3        = FUNCT3_LW;
    bus.mem_write_address = '0;
    bus.mem_write_data    = '0;
    bus.mem_read_address  = '0;
    if (w_if_gnt) begin
      bus.mem_read_address = bus.if_addr;
    end else if (w_d_gnt) begin
      bus.mem_funct3 = bus.d_funct3;
      if (bus.d_we) begin
        bus.mem_write_mem     = 1'b1;
        bus.mem_write_address = bus.d_addr;
        bus.mem_write_data    = bus.d_wdata;
      end else begin
        bus.mem_read_address = bus.d_addr;
      end
    end
  end

  // Reloaded every cycle so back-to-back reads return without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pending <= 1'b0;
      r_rd_owner   <= OWNER_IF;
    end else begin
      r_rd_pending <= w_rd_gnt;
      if (w_rd_gnt) begin
        r_rd_owner <= w_if_gnt ? OWNER_IF : OWNER_D;
      end
    end
  end

  // Gated by rst so a read granted just before reset never returns.
  assign w_if_rvalid   = r_rd_pending && (r_rd_owner == OWNER_IF) && !rst;
  assign w_d_rvalid    = r_rd_pending && (r_rd_owner == OWNER_D) && !rst;
  assign bus.if_rvalid = w_if_rvalid;
  assign bus.d_rvalid  = w_d_rvalid;
  assign bus.if_rdata  = w_if_rvalid ? bus.mem_read_data : '0;
  assign bus.d_rdata   = w_d_rvalid ? bus.mem_read_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_contention <= '0;
    end else if (bus.if_req && bus.d_req && (r_contention != {CNT_W{1'b1}})) begin
      r_contention <= r_contention + 1'b1;
    end
  end

  assign contention_count = r_contention;

endmodule
